idu_buf: RTL and testbench
==========================

IDU_BUF -- requirements
Module: idu_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning instruction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter PC_W, default 32, meaning width of carried PC.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_ins input 32, in_pc input PC_W: IFU-side handshake.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, out_pc output PC_W: EXU-side handshake.
REQ-007 SHALL have decoded outputs rs1/rs2/rd (5 each), opcode 7, func3 3, func7 7, imm 32, all from the queue head.
REQ-008 SHALL have 1-bit outputs reg_write, is_csr, is_ecall, is_mret, is_branch, jump_flag, mem_read, mem_write, illegal.
REQ-009 SHALL have port mem_finish input 1 (LSU completion) and port count output $clog2(DEPTH)+1 (occupancy).

Function
REQ-010 SHALL push {in_ins,in_pc} when in_valid&&in_ready; in_ready = (count<DEPTH); no bypass when full.
REQ-011 SHALL use wrap-around read/write pointers mod DEPTH; count +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
REQ-012 SHALL decode combinationally from the head entry; all decoded outputs 0 when queue is empty.
REQ-013 SHALL form imm per RV32I: I (JALR, LOAD, OP-IMM), S (STORE), B (BRANCH), U (LUI, AUIPC), J (JAL); 0 for other opcodes.
REQ-014 SHALL implement states IDLE, MEM with transitions IDLE->MEM on handshake of a LOAD/STORE, MEM->IDLE on mem_finish.
REQ-015 SHALL assert out_valid = (count!=0) && state==IDLE.
REQ-016 SHALL, in IDLE, pop the head on out_valid&&out_ready for non-memory instructions (zero extra latency).
REQ-017 SHALL, on handshake of a LOAD/STORE, keep the head, enter MEM, and assert mem_read (LOAD) or mem_write (STORE) for exactly the next cycle (single pulse, registered).
REQ-018 SHALL, in MEM, pop the head in the cycle mem_finish=1 and return to IDLE; mem_finish in IDLE ignored.
REQ-019 SHALL assert reg_write for LUI, AUIPC, JAL, JALR, OP-IMM, OP, CSR with func3!=0; for LOAD only in MEM while mem_finish=1; never for STORE/BRANCH.
REQ-020 SHALL set is_csr = opcode SYSTEM && func3!=0; is_ecall = ins==0x00000073; is_mret = ins==0x30200073; jump_flag for JAL/JALR; is_branch for BRANCH.
REQ-021 SHALL accept pushes in MEM state while space remains.

Reset
REQ-022 SHALL on rst=1 clear count, pointers, state to IDLE, mem_read=mem_write=0; out_valid=0 and in_ready=1 the cycle after.
REQ-023 SHALL, on reset mid-MEM, abandon the outstanding access without a further pulse; queued entries are discarded.

Configuration
REQ-024 SHALL, with IDU_BUF_ILLEGAL_CHECK_EN defined, drive illegal=1 for a non-empty head whose opcode is outside {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP,SYSTEM,MISC-MEM}, treated as non-memory, reg_write=0.
REQ-025 SHALL, without IDU_BUF_ILLEGAL_CHECK_EN, tie illegal to 0 with unknown opcodes passing as non-memory, reg_write=0.

Verification
REQ-026 Push 0x00500093 (addi x1,x0,5), out_ready=1 -> same cycle out_valid=1, rd=1, imm=5, reg_write=1; popped next edge, count=0.
REQ-027 DEPTH=2, push 3 instrs with out_ready=0 -> in_ready=0 after 2nd push, count=2; 3rd held until a pop.
REQ-028 Push 0x0000A103 (lw x2,0(x1)), handshake -> mem_read=1 exactly one cycle, out_valid=0 until mem_finish; reg_write=1 only in mem_finish cycle; then pop.
REQ-029 Push 0x00112223 (sw x1,4(x2)) -> imm=4, mem_write one-cycle pulse, reg_write=0 throughout; mem_finish after 5 cycles -> pop, IDLE.
REQ-030 rst=1 during MEM with count=2 -> next cycle count=0, out_valid=0, no mem pulse; subsequent push of 0x00000073 -> is_ecall=1.
REQ-031 Head 0x0000007F with IDU_BUF_ILLEGAL_CHECK_EN -> illegal=1, reg_write=0; without macro -> illegal=0.

Source files
------------

// File: rtl/idu_buf_if.sv
// idu_buf_if: IFU-side push, EXU-side pop, decoded head fields and LSU completion for idu_buf.
// Latency: none; this is a plain bundle of wires.
// Backpressure: in_ready/out_ready carry the valid-ready handshakes; slave is the buffer, master the environment.
interface idu_buf_if #(
   parameter int DEPTH = 2,
   parameter int PC_W  = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   // IFU side
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_ins;
   logic [PC_W-1:0] in_pc;

   // EXU side
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;

   // decoded head
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [6:0]      opcode;
   logic [2:0]      func3;
   logic [6:0]      func7;
   logic [31:0]     imm;
   logic            reg_write;
   logic            is_csr;
   logic            is_ecall;
   logic            is_mret;
   logic            is_branch;
   logic            jump_flag;
   logic            mem_read;
   logic            mem_write;
   logic            illegal;

   // LSU completion and occupancy
   logic            mem_finish;
   logic [CW-1:0]   count;

   modport slave (
      input  in_valid, in_ins, in_pc, out_ready, mem_finish,
      output in_ready, out_valid, out_pc,
      output rs1, rs2, rd, opcode, func3, func7, imm,
      output reg_write, is_csr, is_ecall, is_mret, is_branch, jump_flag,
      output mem_read, mem_write, illegal, count
   );

   modport master (
      output in_valid, in_ins, in_pc, out_ready, mem_finish,
      input  in_ready, out_valid, out_pc,
      input  rs1, rs2, rd, opcode, func3, func7, imm,
      input  reg_write, is_csr, is_ecall, is_mret, is_branch, jump_flag,
      input  mem_read, mem_write, illegal, count
   );
endinterface

// File: rtl/idu_buf.sv
// idu_buf: instruction queue with combinational RV32I decode of the head; LOAD/STORE park the head in MEM until mem_finish.
// Latency: push visible at head one cycle later; non-memory head pops on the same-cycle handshake; mem_read/mem_write pulse the cycle after.
// Backpressure: in_ready drops when full (no bypass); out_valid held low while a memory access is outstanding.
// Optional: define IDU_BUF_ILLEGAL_CHECK_EN to flag unknown opcodes on the illegal output.
module idu_buf #(
   parameter int DEPTH = 2,
   parameter int PC_W  = 32
) (
   input  logic    clk,
   input  logic    rst,
   idu_buf_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;

   typedef struct packed {
      logic [31:0]     ins;
      logic [PC_W-1:0] pc;
   } entry_t;

   typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_t;

   entry_t          q [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count_q;
   state_t          state, state_nxt;
   logic            mem_read_q, mem_write_q;

   logic            in_rdy, out_vld, push, pop, hs_mem, nonempty;
   logic            is_load, is_store, is_mem;
   entry_t          head;
   logic [31:0]     ins;
   logic [6:0]      opcode;
   logic [2:0]      func3;
   logic [31:0]     imm;
   logic            reg_write;

   assign nonempty = (count_q != '0);
   assign in_rdy   = (count_q < DEPTH_C);
   assign out_vld  = nonempty && (state == IDLE);
   assign push     = bus.in_valid && in_rdy;
   assign head     = q[rd_ptr];

   // An empty queue presents an all-zero word so every decoded field reads 0.
   assign ins      = nonempty ? head.ins : 32'h0;
   assign opcode   = ins[6:0];
   assign func3    = ins[14:12];
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_mem   = is_load || is_store;

   // Handshake/completion FSM: chooses when the head pops and when a memory access starts.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      hs_mem    = 1'b0;
      case (state)
         IDLE: begin
            if (out_vld && bus.out_ready) begin
               if (is_mem) begin
                  hs_mem    = 1'b1;
                  state_nxt = MEM;
               end else begin
                  pop = 1'b1;
               end
            end
         end
         MEM: begin
            if (bus.mem_finish) begin
               pop       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Pointers, occupancy and the one-cycle memory request pulses; reset drops any outstanding access.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         mem_read_q  <= hs_mem && is_load;
         mem_write_q <= hs_mem && is_store;
      end
   end

   // Queue storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) q[wr_ptr] <= '{ins: bus.in_ins, pc: bus.in_pc};
   end

   // Immediate formation by RV32I instruction format.
   always_comb begin
      imm = 32'h0;
      case (opcode)
         OP_JALR, OP_LOAD, OP_OPIMM: imm = {{20{ins[31]}}, ins[31:20]};
         OP_STORE:                   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         OP_BRANCH:                  imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         OP_LUI, OP_AUIPC:           imm = {ins[31:12], 12'h000};
         OP_JAL:                     imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:                    imm = 32'h0;
      endcase
   end

   // Register write-back: a load only writes back in the cycle its data returns.
   always_comb begin
      reg_write = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPIMM, OP_OP: reg_write = 1'b1;
         OP_SYSTEM: reg_write = (func3 != 3'b000);
         OP_LOAD:   reg_write = (state == MEM) && bus.mem_finish;
         default:   reg_write = 1'b0;
      endcase
   end

`ifdef IDU_BUF_ILLEGAL_CHECK_EN
   logic known_op;

   // Opcode whitelist for the illegal-instruction flag.
   always_comb begin
      known_op = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
         OP_STORE, OP_OPIMM, OP_OP, OP_SYSTEM, OP_MISC: known_op = 1'b1;
         default: known_op = 1'b0;
      endcase
   end

   assign bus.illegal = nonempty && !known_op;
`else
   assign bus.illegal = 1'b0;
`endif

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_pc    = nonempty ? head.pc : '0;
   assign bus.count     = count_q;
   assign bus.rs1       = ins[19:15];
   assign bus.rs2       = ins[24:20];
   assign bus.rd        = ins[11:7];
   assign bus.opcode    = opcode;
   assign bus.func3     = func3;
   assign bus.func7     = ins[31:25];
   assign bus.imm       = imm;
   assign bus.reg_write = reg_write;
   assign bus.is_csr    = (opcode == OP_SYSTEM) && (func3 != 3'b000);
   assign bus.is_ecall  = (ins == 32'h0000_0073);
   assign bus.is_mret   = (ins == 32'h3020_0073);
   assign bus.is_branch = (opcode == OP_BRANCH);
   assign bus.jump_flag = (opcode == OP_JAL) || (opcode == OP_JALR);
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
endmodule

// File: tb/tb_idu_buf.sv
// tb_idu_buf: per-cycle vector table for idu_buf (DEPTH=2) plus a hand-written load sequence.
// Latency: each row drives inputs after a rising edge and checks outputs on the following falling edge.
// Backpressure: rows exercise full queue, MEM stalls, simultaneous push/pop and reset mid-access.
module tb_idu_buf;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   idu_buf_if #(.DEPTH(2), .PC_W(32)) bus ();

   idu_buf #(.DEPTH(2), .PC_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

`ifdef IDU_BUF_ILLEGAL_CHECK_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] ins;
      logic        ordy;
      logic        mfin;
      logic        ovld;
      logic        irdy;
      logic [1:0]  cnt;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        rw;
      logic        mrd;
      logic        mwr;
      logic        ecl;
      logic        ill;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   function automatic vec_t mk(input logic r, iv, input logic [31:0] ins, input logic ordy, mfin,
                               input logic ovld, irdy, input logic [1:0] cnt, input logic [4:0] rd,
                               input logic [31:0] imm, input logic rw, mrd, mwr, ecl, ill);
      vec_t v;
      v.rst = r;   v.iv = iv;     v.ins = ins;   v.ordy = ordy; v.mfin = mfin;
      v.ovld = ovld; v.irdy = irdy; v.cnt = cnt; v.rd = rd;     v.imm = imm;
      v.rw = rw;   v.mrd = mrd;   v.mwr = mwr;   v.ecl = ecl;   v.ill = ill;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      int rd_pulses;
      int vld_seen;
      bit done;

      bus.in_valid   = 1'b0;
      bus.in_ins     = 32'h0;
      bus.in_pc      = 32'h0;
      bus.out_ready  = 1'b0;
      bus.mem_finish = 1'b0;

      //               rst iv ins           ordy mfin ovld irdy cnt rd  imm           rw mrd mwr ecl ill
      tbl.push_back(mk(0, 0, 32'h00000000, 0, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0)); // post-reset
      tbl.push_back(mk(0, 1, 32'h00500093, 1, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0)); // addi, no bypass
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   1, 1, 1, 1,  32'h5,        1, 0, 0, 0, 0)); // popped
      tbl.push_back(mk(0, 0, 32'h00000000, 0, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h00100113, 0, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0)); // fill
      tbl.push_back(mk(0, 1, 32'h00200193, 0, 0,   1, 1, 1, 2,  32'h1,        1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h00300213, 0, 0,   1, 0, 2, 2,  32'h1,        1, 0, 0, 0, 0)); // full, held
      tbl.push_back(mk(0, 1, 32'h00300213, 1, 0,   1, 0, 2, 2,  32'h1,        1, 0, 0, 0, 0)); // pop only
      tbl.push_back(mk(0, 1, 32'h00300213, 0, 0,   1, 1, 1, 3,  32'h2,        1, 0, 0, 0, 0)); // 3rd accepted
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   1, 0, 2, 3,  32'h2,        1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   1, 1, 1, 4,  32'h3,        1, 0, 0, 0, 0)); // wrapped slot
      tbl.push_back(mk(0, 1, 32'h0000A103, 0, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0)); // lw
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   1, 1, 1, 2,  32'h0,        0, 0, 0, 0, 0)); // -> MEM
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   0, 1, 1, 2,  32'h0,        0, 1, 0, 0, 0)); // pulse
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   0, 1, 1, 2,  32'h0,        0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 1,   0, 1, 1, 2,  32'h0,        1, 0, 0, 0, 0)); // finish
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h00112223, 0, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0)); // sw
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   1, 1, 1, 4,  32'h4,        0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   0, 1, 1, 4,  32'h4,        0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 32'h00500093, 1, 0,   0, 1, 1, 4,  32'h4,        0, 0, 0, 0, 0)); // push in MEM
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   0, 0, 2, 4,  32'h4,        0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   0, 0, 2, 4,  32'h4,        0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 1,   0, 0, 2, 4,  32'h4,        0, 0, 0, 0, 0)); // finish
      tbl.push_back(mk(0, 0, 32'h00000000, 0, 0,   1, 1, 1, 1,  32'h5,        1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h00000000, 0, 1,   1, 1, 1, 1,  32'h5,        1, 0, 0, 0, 0)); // finish ignored
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   1, 1, 1, 1,  32'h5,        1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h0000A103, 0, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h00500093, 1, 0,   1, 1, 1, 2,  32'h0,        0, 0, 0, 0, 0)); // -> MEM, cnt 2
      tbl.push_back(mk(1, 0, 32'h00000000, 1, 0,   0, 0, 2, 2,  32'h0,        0, 1, 0, 0, 0)); // reset mid-MEM
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 32'h00000073, 0, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0)); // ecall
      tbl.push_back(mk(0, 0, 32'h00000000, 0, 0,   1, 1, 1, 0,  32'h0,        0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   1, 1, 1, 0,  32'h0,        0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 32'h0000007F, 0, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0)); // unknown op
      tbl.push_back(mk(0, 0, 32'h00000000, 0, 0,   1, 1, 1, 0,  32'h0,        0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   1, 1, 1, 0,  32'h0,        0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 32'h008000EF, 1, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0)); // jal
      tbl.push_back(mk(0, 1, 32'hFE000EE3, 1, 0,   1, 1, 1, 1,  32'h8,        1, 0, 0, 0, 0)); // beq, push+pop
      tbl.push_back(mk(0, 1, 32'h123450B7, 1, 0,   1, 1, 1, 29, 32'hFFFFFFFC, 0, 0, 0, 0, 0)); // lui
      tbl.push_back(mk(0, 0, 32'h00000000, 1, 0,   1, 1, 1, 1,  32'h12345000, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h00000000, 0, 0,   0, 1, 0, 0,  32'h0,        0, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         rst            = tbl[i].rst;
         bus.in_valid   = tbl[i].iv;
         bus.in_ins     = tbl[i].ins;
         bus.in_pc      = 32'h1000 + 32'(i * 4);
         bus.out_ready  = tbl[i].ordy;
         bus.mem_finish = tbl[i].mfin;
         @(negedge clk);
         check($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ovld));
         check($sformatf("v%0d.in_ready", i),  32'(bus.in_ready),  32'(tbl[i].irdy));
         check($sformatf("v%0d.count", i),     32'(bus.count),     32'(tbl[i].cnt));
         check($sformatf("v%0d.rd", i),        32'(bus.rd),        32'(tbl[i].rd));
         check($sformatf("v%0d.imm", i),       bus.imm,            tbl[i].imm);
         check($sformatf("v%0d.reg_write", i), 32'(bus.reg_write), 32'(tbl[i].rw));
         check($sformatf("v%0d.mem_read", i),  32'(bus.mem_read),  32'(tbl[i].mrd));
         check($sformatf("v%0d.mem_write", i), 32'(bus.mem_write), 32'(tbl[i].mwr));
         check($sformatf("v%0d.is_ecall", i),  32'(bus.is_ecall),  32'(tbl[i].ecl));
         check($sformatf("v%0d.illegal", i),   32'(bus.illegal),   32'(tbl[i].ill & ILL_EN));
         @(posedge clk);
         #1;
      end

      // Hand sequence: load carrying a PC, long LSU stall, single mem_read pulse, bounded wait for completion.
      rst            = 1'b0;
      bus.in_valid   = 1'b1;
      bus.in_ins     = 32'h0000A103;
      bus.in_pc      = 32'h8000_0040;
      bus.out_ready  = 1'b0;
      bus.mem_finish = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("seq.out_pc", bus.out_pc, 32'h8000_0040);
      check("seq.is_load_opcode", 32'(bus.opcode), 32'h03);
      @(posedge clk);
      #1;
      rd_pulses = 0;
      vld_seen  = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.mem_read)  rd_pulses++;
         if (bus.out_valid) vld_seen++;
         @(posedge clk);
         #1;
      end
      check("seq.mem_read_pulses", 32'(rd_pulses), 32'd1);
      check("seq.out_valid_in_mem", 32'(vld_seen), 32'd0);
      bus.mem_finish = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         @(negedge clk);
         if (bus.reg_write) done = 1'b1;
         @(posedge clk);
         #1;
      end
      check("seq.load_writeback_seen", 32'(done), 32'd1);
      bus.mem_finish = 1'b0;
      @(negedge clk);
      check("seq.count_after_finish", 32'(bus.count), 32'd0);
      check("seq.out_valid_after_finish", 32'(bus.out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
